spmv_row_accumulator: RTL and testbench
=======================================

# spmv_row_accumulator

Consumes the per-lane (id, partial-sum) stream produced by the SpMV reduction network and accumulates the partial sums into a bank of per-row accumulators indexed by row id. On a flush request, it drains every row sum in ascending id order on a single output stream and clears each entry as it is read. It sits directly downstream of `spmv_reduction_network` and feeds the result write-back path.

## Interface
- NETWORK_WIDTH, 32, number of input lanes (power of two, ≥2)
- IN_WIDTH, 64, width of incoming partial sums (two's complement); matches reduction network OUT_WIDTH
- ID_WIDTH, 5, row id width; bank depth DEPTH = 2^ID_WIDTH
- ACC_WIDTH, 80, accumulator width, ≥ IN_WIDTH
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  NETWORK_WIDTH  per-lane valid
- in_id  in  ID_WIDTH x NETWORK_WIDTH (unpacked)  per-lane row id
- in_val  in  IN_WIDTH x NETWORK_WIDTH (unpacked)  per-lane partial sum
- in_ready  out  NETWORK_WIDTH  per-lane ready, at most one bit set
- flush  in  1  single-cycle request to drain the bank
- busy  out  1  high while draining
- out_valid  out  1  result valid
- out_id  out  ID_WIDTH  row id of result
- out_val  out  ACC_WIDTH  row sum
- out_last  out  1  marks id DEPTH-1
- out_ready  in  1  downstream ready

## Operation
- States: ACCUM (reset state) and FLUSH.
- ACCUM arbitration:
  - Round-robin pointer `ptr`, reset value 0.
  - Grant goes to the first lane with in_valid=1, searching from index ptr upward and wrapping.
  - in_ready is one-hot on the granted lane, or all zero if no lane is valid.
  - in_ready is combinational from in_valid and ptr.
- Accept: in_valid[g] & in_ready[g].
  - On accept, bank[in_id[g]] <= bank[in_id[g]] + sign_extend(in_val[g]) at the same edge.
  - On accept, ptr <= (g+1) mod NETWORK_WIDTH.
  - Without an accept, ptr holds.
- Arithmetic: sum wraps modulo 2^ACC_WIDTH. No saturation and no overflow flag.
- Back-to-back accepts to the same id accumulate correctly. The bank is a register array, so there is no read-after-write hazard.
- flush = 1 in ACCUM:
  - An accept in the same cycle is still applied.
  - Next state is FLUSH, with drain counter cnt <= 0.
- FLUSH:
  - in_ready = 0 on all lanes.
  - out_valid = 1, out_id = cnt, out_val = bank[cnt], out_last = (cnt == DEPTH-1).
  - On out_valid & out_ready: bank[cnt] <= 0 and cnt <= cnt+1. If out_last, return to ACCUM.
  - Outputs are stable while out_ready = 0.
- flush asserted while in FLUSH is ignored and is not queued.
- busy = (state == FLUSH).
- Reset (asynchronous, any time, including mid-drain):
  - state = ACCUM, ptr = 0, cnt = 0, all bank entries = 0.
  - in_ready = 0 while rst_n = 0.
  - out_valid = 0, out_id = 0, out_val = 0, out_last = 0, busy = 0.
  - A partially drained bank is discarded.

## Timing
- Input-to-bank latency is 1 cycle. The entry reflects an accept at edge k from edge k onward.
- Throughput is one input beat per cycle across all lanes combined. Lanes that are not granted hold their data per valid/ready.
- A lane held valid is granted within NETWORK_WIDTH cycles (no starvation).
- flush at edge k: busy = 1 and out_valid = 1 from cycle k+1.
- Drain takes exactly DEPTH cycles with out_ready held high. The return to ACCUM happens at the edge of the last handshake, and in_ready may assert in the following cycle.
- Outside FLUSH, out_valid = 0 and the remaining outputs are 0.

## Test plan
Configuration for all scenarios: NETWORK_WIDTH=4, ID_WIDTH=3, IN_WIDTH=8, ACC_WIDTH=16.

- Reset values: assert rst_n=0 mid-drain -> all outputs 0. After release, flush drains 8 results all 0, ids 0..7, out_last only on id 7.
- Round-robin arbitration: all 4 lanes continuously valid, id=i, val=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Flush yields ids 0..3 = 2 and ids 4..7 = 0.
- Signed accumulation and wrap: id 5 receives 0x7F x 300 then 0x80 x 1 (-128) -> out_val[5] = (300*127 - 128) mod 65536 = 37972. A second flush returns 0.
- Same-id back-to-back: one lane, id 2, vals 3,4,5 on consecutive cycles -> out_val = 12.
- Flush with accept in the same cycle: accept id 1, val 9 with flush=1 -> id 1 drains 9. in_ready=0 from the next cycle until after out_last.
- Output backpressure: during drain, toggle out_ready 1,0,0,1 -> out_id/out_val held steady while out_ready=0. A flush pulse inside FLUSH has no effect. Exactly 8 handshakes occur.

Source files
------------

// File: rtl/spmv_row_accumulator.sv
`timescale 1ns/1ps
// spmv_row_accumulator
// Collects per-lane (row id, partial sum) beats from the reduction network
// into a bank of per-row accumulators. A flush drains every row in ascending
// id order on a single output stream, clearing each entry as it is read.
module spmv_row_accumulator #(
   parameter int NETWORK_WIDTH = 32,
   parameter int IN_WIDTH      = 64,
   parameter int ID_WIDTH      = 5,
   parameter int ACC_WIDTH     = 80
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NETWORK_WIDTH-1:0] in_valid,
   input  logic [ID_WIDTH-1:0]      in_id  [NETWORK_WIDTH],
   input  logic [IN_WIDTH-1:0]      in_val [NETWORK_WIDTH],
   output logic [NETWORK_WIDTH-1:0] in_ready,
   input  logic                     flush,
   output logic                     busy,
   output logic                     out_valid,
   output logic [ID_WIDTH-1:0]      out_id,
   output logic [ACC_WIDTH-1:0]     out_val,
   output logic                     out_last,
   input  logic                     out_ready
);

   localparam int DEPTH = 1 << ID_WIDTH;
   localparam int PTR_W = $clog2(NETWORK_WIDTH);

   typedef enum logic {ACCUM, FLUSH} state_t;

   state_t                      state;
   logic [PTR_W-1:0]            ptr;
   logic [ID_WIDTH-1:0]         cnt;
   logic signed [ACC_WIDTH-1:0] bank [DEPTH];

   logic                        grant_any;
   logic [PTR_W-1:0]            grant;
   logic [PTR_W-1:0]            idx;
   logic                        accept;

   // Two's-complement widening of an incoming partial sum.
   function automatic logic signed [ACC_WIDTH-1:0] sext(input logic signed [IN_WIDTH-1:0] v);
      return ACC_WIDTH'(v);
   endfunction

   // Accumulation deliberately wraps modulo 2^ACC_WIDTH; no saturation.
   function automatic logic signed [ACC_WIDTH-1:0] wrap_add(input logic signed [ACC_WIDTH-1:0] a,
                                                             input logic signed [ACC_WIDTH-1:0] b);
      return a + b;
   endfunction

   // Round-robin search: first valid lane starting at ptr, wrapping around.
   always_comb begin
      grant_any = 1'b0;
      grant     = '0;
      idx       = '0;
      for (int i = 0; i < NETWORK_WIDTH; i++) begin
         idx = ptr + PTR_W'(i);
         if (!grant_any && in_valid[idx]) begin
            grant_any = 1'b1;
            grant     = idx;
         end
      end
   end

   // Inputs are only taken while accumulating and never during reset.
   assign accept = rst_n && (state == ACCUM) && grant_any;

   // One-hot ready on the granted lane.
   always_comb begin
      in_ready = '0;
      if (accept) in_ready[grant] = 1'b1;
   end

   // Control FSM, arbitration pointer, drain counter and accumulator bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCUM;
         ptr   <= '0;
         cnt   <= '0;
         for (int d = 0; d < DEPTH; d++) bank[d] <= '0;
      end else begin
         case (state)
            ACCUM: begin
               // An accept coinciding with flush still lands before the drain.
               if (accept) begin
                  bank[in_id[grant]] <= wrap_add(bank[in_id[grant]], sext(in_val[grant]));
                  ptr                <= grant + 1'b1;
               end
               if (flush) begin
                  state <= FLUSH;
                  cnt   <= '0;
               end
            end
            FLUSH: begin
               // Read-and-clear; flush requests here are dropped, not queued.
               if (out_ready) begin
                  bank[cnt] <= '0;
                  cnt       <= cnt + 1'b1;
                  if (&cnt) state <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

   // Outputs decode registered state only, so they hold steady under backpressure.
   assign busy      = (state == FLUSH);
   assign out_valid = busy;
   assign out_id    = busy ? cnt : '0;
   assign out_val   = busy ? bank[cnt] : '0;
   assign out_last  = busy & (&cnt);

endmodule

// File: tb/tb_spmv_row_accumulator.sv
`timescale 1ns/1ps
// Directed bench for spmv_row_accumulator (4 lanes, 8 rows, 8-bit in, 16-bit acc).
module tb_spmv_row_accumulator;

   localparam int NW  = 4;
   localparam int IDW = 3;
   localparam int INW = 8;
   localparam int ACW = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NW-1:0]   in_valid;
   logic [IDW-1:0]  in_id  [NW];
   logic [INW-1:0]  in_val [NW];
   logic [NW-1:0]   in_ready;
   logic            flush;
   logic            busy;
   logic            out_valid;
   logic [IDW-1:0]  out_id;
   logic [ACW-1:0]  out_val;
   logic            out_last;
   logic            out_ready;

   int checks = 0;
   int errors = 0;

   // Drain capture
   int              g_n;
   logic            g_rdy_seen;
   logic [IDW-1:0]  g_id   [8];
   logic [ACW-1:0]  g_val  [8];
   logic            g_last [8];

   spmv_row_accumulator #(
      .NETWORK_WIDTH(NW), .IN_WIDTH(INW), .ID_WIDTH(IDW), .ACC_WIDTH(ACW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_id(in_id), .in_val(in_val),
      .in_ready(in_ready), .flush(flush), .busy(busy), .out_valid(out_valid),
      .out_id(out_id), .out_val(out_val), .out_last(out_last), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      in_valid  = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < NW; i++) begin
         in_id[i]  = '0;
         in_val[i] = '0;
      end
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   // Drains with out_ready high, recording every valid beat (bounded).
   task automatic drain_collect();
      logic done;
      done       = 1'b0;
      g_n        = 0;
      g_rdy_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         g_id[i] = '0; g_val[i] = '0; g_last[i] = 1'b0;
      end
      out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (in_ready !== '0) g_rdy_seen = 1'b1;
         if (out_valid === 1'b1) begin
            if (g_n < 8) begin
               g_id[g_n]   = out_id;
               g_val[g_n]  = out_val;
               g_last[g_n] = out_last;
            end
            g_n++;
            done = out_last;
         end
         step();
         if (done) break;
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      in_valid = 4'b1111;
      #1;
      checks++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_initial: in_ready=%b out_valid=%b busy=%b, required 0000 0 0", in_ready, out_valid, busy);
      end
      in_valid = '0;
      step();
      rst_n = 1'b1;
      // Put data in row 6 so a discarded partial drain is observable.
      in_valid = 4'b0001; in_id[0] = 3'd6; in_val[0] = 8'd5;
      step();
      in_valid = '0;
      do_flush();
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b1 || out_id !== 3'd0) begin
         errors++;
         $display("FAIL reset_flush_start: busy=%b out_valid=%b out_id=%0d, required 1 1 0", busy, out_valid, out_id);
      end
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      #2 rst_n = 1'b0;
      in_valid = 4'b1111;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_id !== 3'd0 || out_val !== 16'd0 || out_last !== 1'b0 ||
          busy !== 1'b0 || in_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_mid_drain: valid=%b id=%0d val=%0d last=%b busy=%b rdy=%b, required all 0",
                  out_valid, out_id, out_val, out_last, busy, in_ready);
      end
      in_valid = '0;
      step();
      rst_n = 1'b1;
      step();
      do_flush();
      drain_collect();
      checks++;
      if (g_n !== 8) begin
         errors++;
         $display("FAIL reset_drain_count: got %0d beats, required 8", g_n);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (g_id[i] !== 3'(i) || g_val[i] !== 16'd0 || g_last[i] !== (i == 7)) begin
            errors++;
            $display("FAIL reset_drain_beat%0d: id=%0d val=%0d last=%b, required id=%0d val=0 last=%0d",
                     i, g_id[i], g_val[i], g_last[i], i, (i == 7));
         end
      end
   endtask

   task automatic test_round_robin();
      logic [NW-1:0] exp_rdy;
      for (int i = 0; i < NW; i++) begin
         in_id[i]  = 3'(i);
         in_val[i] = 8'd1;
      end
      in_valid = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         exp_rdy = 4'(1 << (c % 4));
         #0;
         checks++;
         if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL rr_grant_cycle%0d: in_ready=%b, required %b", c, in_ready, exp_rdy);
         end
         step();
      end
      in_valid = '0;
      do_flush();
      drain_collect();
      checks++;
      if (g_n !== 8) begin
         errors++;
         $display("FAIL rr_drain_count: got %0d beats, required 8", g_n);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (g_val[i] !== ((i < 4) ? 16'd2 : 16'd0)) begin
            errors++;
            $display("FAIL rr_row%0d: val=%0d, required %0d", i, g_val[i], (i < 4) ? 2 : 0);
         end
      end
   endtask

   task automatic test_signed_wrap();
      in_valid = 4'b0001; in_id[0] = 3'd5; in_val[0] = 8'h7F;
      for (int c = 0; c < 300; c++) step();
      in_val[0] = 8'h80;
      step();
      in_valid = '0;
      do_flush();
      drain_collect();
      checks++;
      if (g_n !== 8 || g_val[5] !== 16'd37972) begin
         errors++;
         $display("FAIL wrap_row5: beats=%0d val=%0d, required 8 and 37972", g_n, g_val[5]);
      end
      checks++;
      if (g_val[4] !== 16'd0 || g_val[6] !== 16'd0) begin
         errors++;
         $display("FAIL wrap_neighbours: row4=%0d row6=%0d, required 0 0", g_val[4], g_val[6]);
      end
      do_flush();
      drain_collect();
      checks++;
      if (g_n !== 8 || g_val[5] !== 16'd0) begin
         errors++;
         $display("FAIL wrap_second_flush: beats=%0d row5=%0d, required 8 and 0", g_n, g_val[5]);
      end
   endtask

   task automatic test_back_to_back();
      in_valid = 4'b0100; in_id[2] = 3'd2;
      in_val[2] = 8'd3; step();
      in_val[2] = 8'd4; step();
      in_val[2] = 8'd5; step();
      in_valid = '0;
      do_flush();
      drain_collect();
      checks++;
      if (g_n !== 8 || g_val[2] !== 16'd12) begin
         errors++;
         $display("FAIL b2b_row2: beats=%0d val=%0d, required 8 and 12", g_n, g_val[2]);
      end
   endtask

   task automatic test_flush_accept();
      in_valid = 4'b0010; in_id[1] = 3'd1; in_val[1] = 8'd9;
      flush = 1'b1;
      #0;
      checks++;
      if (in_ready !== 4'b0010) begin
         errors++;
         $display("FAIL fa_grant: in_ready=%b, required 0010", in_ready);
      end
      step();
      flush = 1'b0;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b1 || in_ready !== 4'b0000) begin
         errors++;
         $display("FAIL fa_enter_flush: busy=%b out_valid=%b in_ready=%b, required 1 1 0000", busy, out_valid, in_ready);
      end
      drain_collect();
      checks++;
      if (g_n !== 8 || g_val[1] !== 16'd9) begin
         errors++;
         $display("FAIL fa_row1: beats=%0d val=%0d, required 8 and 9", g_n, g_val[1]);
      end
      checks++;
      if (g_rdy_seen !== 1'b0) begin
         errors++;
         $display("FAIL fa_ready_in_drain: in_ready seen=%b, required 0", g_rdy_seen);
      end
      checks++;
      if (in_ready !== 4'b0010 || busy !== 1'b0) begin
         errors++;
         $display("FAIL fa_ready_after: in_ready=%b busy=%b, required 0010 0", in_ready, busy);
      end
      in_valid = '0;
   endtask

   task automatic test_backpressure();
      logic [3:0]     pat;
      logic [IDW-1:0] prev_id;
      logic [ACW-1:0] prev_val;
      logic [ACW-1:0] row4;
      logic           prev_ready;
      int             hs;
      pat = 4'b1001;
      hs = 0; prev_ready = 1'b1; prev_id = '0; prev_val = '0; row4 = '0;
      // ptr now at lane 2, lane 3 still found by the wrap search.
      in_valid = 4'b1000; in_id[3] = 3'd4; in_val[3] = 8'hFD;
      step();
      in_valid = '0;
      do_flush();
      for (int c = 0; c < 40; c++) begin
         out_ready = pat[c % 4];
         flush     = (c == 2);
         #0;
         if (out_valid !== 1'b1) break;
         if (!prev_ready) begin
            checks++;
            if (out_id !== prev_id || out_val !== prev_val) begin
               errors++;
               $display("FAIL bp_hold_cycle%0d: id=%0d val=%0d, required id=%0d val=%0d",
                        c, out_id, out_val, prev_id, prev_val);
            end
         end
         if (out_id == 3'd4) row4 = out_val;
         if (out_ready) hs++;
         prev_ready = out_ready;
         prev_id    = out_id;
         prev_val   = out_val;
         step();
      end
      flush     = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (hs !== 8) begin
         errors++;
         $display("FAIL bp_handshakes: got %0d, required 8", hs);
      end
      checks++;
      if (row4 !== 16'd65533) begin
         errors++;
         $display("FAIL bp_row4: val=%0d, required 65533", row4);
      end
      step();
      step();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_flush_not_queued: busy=%b out_valid=%b, required 0 0", busy, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_signed_wrap();
      test_back_to_back();
      test_flush_accept();
      test_backpressure();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
